// File: rtl/cpu_with_memory.sv
// Single-cycle 16-bit-instruction core with an 8x32 register file, 64x32 RAM, an SW input and an LED register.
// One instruction retires per clk edge. There is no backpressure; loads and stores complete in the same cycle.
module cpu_with_memory (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SW,
  output logic [31:0] LED
);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;

  logic [5:0]  pc_q, pc_d;
  logic [31:0] rf_q [8];
  logic [31:0] ram_q [64];
  logic [31:0] led_q;

  logic [15:0] instr;
  logic [3:0]  op;
  logic [2:0]  rd, rs, rt;
  logic [31:0] imm;
  logic [31:0] rd_val, rs_val, rt_val, ea;
  logic [7:0]  addr;
  logic [31:0] ld_dat;
  logic        wr_en_d, st_en_d;
  logic [31:0] wr_dat_d;

  always_comb begin
    instr = 16'h0000;
    case (pc_q)
      6'd0:    instr = 16'h723E;
      6'd1:    instr = 16'h6241;
      6'd2:    instr = 16'h823F;
      6'd3:    instr = 16'hA000;
      default: instr = 16'h0000;
    endcase
  end

  assign op     = instr[15:12];
  assign rd     = instr[11:9];
  assign rs     = instr[8:6];
  assign rt     = instr[5:3];
  assign imm    = {{26{instr[5]}}, instr[5:0]};
  assign rd_val = (rd == 3'd0) ? 32'd0 : rf_q[rd];
  assign rs_val = (rs == 3'd0) ? 32'd0 : rf_q[rs];
  assign rt_val = (rt == 3'd0) ? 32'd0 : rf_q[rt];
  assign ea     = rs_val + imm;
  assign addr   = ea[7:0];
  assign LED    = led_q;

  // Data address decode: RAM low, SW and LED at the top two addresses.
  always_comb begin
    ld_dat = 32'd0;
    if (addr[7:6] == 2'b00) ld_dat = ram_q[addr[5:0]];
    else if (addr == 8'hFE) ld_dat = SW;
    else if (addr == 8'hFF) ld_dat = led_q;
  end

  always_comb begin
    pc_d     = pc_q + 6'd1;
    wr_en_d  = 1'b0;
    st_en_d  = 1'b0;
    wr_dat_d = 32'd0;
    case (op)
      OP_ADD:  begin wr_en_d = 1'b1; wr_dat_d = rs_val + rt_val; end
      OP_SUB:  begin wr_en_d = 1'b1; wr_dat_d = rs_val - rt_val; end
      OP_AND:  begin wr_en_d = 1'b1; wr_dat_d = rs_val & rt_val; end
      OP_OR:   begin wr_en_d = 1'b1; wr_dat_d = rs_val | rt_val; end
      OP_XOR:  begin wr_en_d = 1'b1; wr_dat_d = rs_val ^ rt_val; end
      OP_ADDI: begin wr_en_d = 1'b1; wr_dat_d = ea; end
      OP_LD:   begin wr_en_d = 1'b1; wr_dat_d = ld_dat; end
      OP_ST:   st_en_d = 1'b1;
      OP_BEQ:  if (rd_val == rs_val) pc_d = pc_q + 6'd1 + instr[5:0];
      OP_JMP:  pc_d = instr[5:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= 6'd0;
      led_q <= 32'd0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (wr_en_d && rd != 3'd0) rf_q[rd] <= wr_dat_d;
      if (st_en_d && addr == 8'hFF) led_q <= rd_val;
    end
  end

  // RAM has no reset; contents are undefined until software writes them.
  always_ff @(posedge clk) begin
    if (reset && st_en_d && addr[7:6] == 2'b00) ram_q[addr[5:0]] <= rd_val;
  end

endmodule

// File: tb/tb_cpu_with_memory.sv
`timescale 1ns/1ps
// Directed bench for cpu_with_memory running its fixed SW -> LED+1 program.
module tb_cpu_with_memory;

  logic        clk;
  logic        reset;
  logic [31:0] SW;
  logic [31:0] LED;

  int n_chk  = 0;
  int n_pass = 0;

  cpu_with_memory dut (
    .clk   (clk),
    .reset (reset),
    .SW    (SW),
    .LED   (LED)
  );

  initial clk = 1'b0;
  always #200 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait up to budget cycles for LED==exp; any value other than old or exp counts as a glitch.
  task automatic wait_led(input string tag, input logic [31:0] old, input logic [31:0] exp,
                          input int budget);
    int bad;
    bad = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (LED === exp) break;
      if (LED !== old) bad++;
    end
    chk(tag, LED, exp);
    chk({tag, "_glitch"}, bad, 0);
  endtask

  initial begin
    reset = 1'b0;
    SW    = 32'h5;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_led", LED, 32'h0);
      chk("rst_pc", {26'd0, dut.pc_q}, 32'h0);
    end

    reset = 1'b1;
    cyc(); chk("rel_e1", LED, 32'h0);
    cyc(); chk("rel_e2", LED, 32'h0);
    cyc(); chk("rel_e3", LED, 32'h6);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rel_stable", LED, 32'h6);
    end

    SW = 32'hFFFF_FFFF;
    wait_led("wrap", 32'h6, 32'h0, 8);

    SW = 32'h10;
    wait_led("sw10", 32'h0, 32'h11, 8);
    cyc(); cyc();
    SW = 32'h11;
    wait_led("sw11", 32'h11, 32'h12, 8);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("sw11_stable", LED, 32'h12);
    end

    // Abort the store: reset lands on the edge that would end the ST at PC=2.
    for (int i = 0; i < 8 && dut.pc_q != 6'd2; i++) cyc();
    chk("mid_pc2", {26'd0, dut.pc_q}, 32'h2);
    reset = 1'b0;
    cyc();
    chk("mid_led", LED, 32'h0);
    chk("mid_pc", {26'd0, dut.pc_q}, 32'h0);
    chk("mid_r1", dut.rf_q[1], 32'h0);
    reset = 1'b1;
    cyc(); chk("mid_e1", LED, 32'h0);
    cyc(); chk("mid_e2", LED, 32'h0);
    cyc(); chk("mid_e3", LED, 32'h12);

    // 400 ns clock: 10 us between SW changes, 1.6 us = 4 cycles to reach SW+1.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] prev;
      prev = LED;
      SW   = 32'h100 * k + 32'h7;
      wait_led("per", prev, SW + 32'h1, 4);
      for (int i = 0; i < 21; i++) cyc();
      chk("per_hold", LED, SW + 32'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
